// File: rtl/motor_sched_pkg.sv
// rtl/motor_sched_pkg.sv - shared speed types and limits for the motor ramp scheduler
package motor_sched_pkg;

  localparam int SPD_W = 11;

  typedef logic signed [SPD_W-1:0] spd_t;

  localparam spd_t SPD_MAX = 11'sd1023;
  localparam spd_t SPD_MIN = -11'sd1023;

  typedef enum logic {RAMP = 1'b0, BRAKE = 1'b1} side_st_t;

  // motor_cntrl drives a 10-bit magnitude, so -1024 is folded onto -1023
  function automatic spd_t sat_spd(input spd_t v);
    if (v < SPD_MIN) return SPD_MIN;
    if (v > SPD_MAX) return SPD_MAX;
    return v;
  endfunction

endpackage

// File: rtl/motor_ramp_sched_ramp_side.sv
// rtl/motor_ramp_sched_ramp_side.sv - one wheel: bounded-slew ramp with brake dwell on reversal
module ramp_side
  import motor_sched_pkg::*;
#(
  parameter int STEP        = 8,
  parameter int BRAKE_TICKS = 50
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     tick,
  input  logic     clear,
  input  spd_t     tgt,
  output spd_t     cur,
  output side_st_t state,
  output logic     brake
);

  localparam int BW = (BRAKE_TICKS > 1) ? $clog2(BRAKE_TICKS) : 1;
  localparam logic [BW-1:0] BRK_LOAD = BW'(BRAKE_TICKS - 1);
  localparam spd_t STEP_V = spd_t'(STEP);
  localparam logic signed [SPD_W:0] STEP_W = (SPD_W + 1)'(STEP);

  logic [BW-1:0]           brk_cnt;
  logic                    reversal;
  spd_t                    aim;
  logic signed [SPD_W:0]   diff;
  logic signed [SPD_W:0]   mag;
  spd_t                    nxt_cur;

  // A reversal first aims at zero; the real target is chased only after the dwell
  always_comb begin
    reversal = (cur != '0) && (tgt != '0) && (cur[SPD_W-1] != tgt[SPD_W-1]);
    aim      = reversal ? '0 : tgt;
    diff     = {aim[SPD_W-1], aim} - {cur[SPD_W-1], cur};
    mag      = diff[SPD_W] ? -diff : diff;
    if (mag <= STEP_W)
      nxt_cur = aim;
    else if (diff[SPD_W])
      nxt_cur = cur - STEP_V;
    else
      nxt_cur = cur + STEP_V;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cur     <= '0;
      state   <= RAMP;
      brk_cnt <= '0;
    end else if (tick) begin
      case (state)
        RAMP: begin
          cur <= nxt_cur;
          if (reversal && (nxt_cur == '0)) begin
            state   <= BRAKE;
            brk_cnt <= BRK_LOAD;
          end
        end
        BRAKE: begin
          if (brk_cnt == '0)
            state <= RAMP;
          else
            brk_cnt <= brk_cnt - BW'(1);
        end
        default: state <= RAMP;
      endcase
    end
  end

  assign brake = (state == BRAKE);

endmodule

// File: rtl/motor_ramp_sched.sv
// rtl/motor_ramp_sched.sv - slew-rate scheduler feeding signed wheel speeds to motor_cntrl
module motor_ramp_sched
  import motor_sched_pkg::*;
#(
  parameter int TICK_DIV    = 1000,
  parameter int STEP        = 8,
  parameter int BRAKE_TICKS = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic signed [10:0] cmd_lft,
  input  logic signed [10:0] cmd_rht,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic              estop,
  output logic signed [10:0] lft,
  output logic signed [10:0] rht,
  output logic              at_tgt
);

  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic          accept;
  spd_t          tgt_l;
  spd_t          tgt_r;
  side_st_t      st_l;
  side_st_t      st_r;
  logic          brk_l;
  logic          brk_r;

  assign tick    = (pre_cnt == PW'(TICK_DIV - 1));
  assign cmd_rdy = !estop && !brk_l && !brk_r;
  assign accept  = cmd_vld && cmd_rdy;

  // estop shares the reset path so the prescaler phase restarts cleanly afterwards
  always_ff @(posedge clk) begin
    if (rst || estop) begin
      pre_cnt <= '0;
      tgt_l   <= '0;
      tgt_r   <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      if (accept) begin
        tgt_l <= sat_spd(cmd_lft);
        tgt_r <= sat_spd(cmd_rht);
      end
    end
  end

  ramp_side #(.STEP(STEP), .BRAKE_TICKS(BRAKE_TICKS)) u_side_l (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .clear (estop),
    .tgt   (tgt_l),
    .cur   (lft),
    .state (st_l),
    .brake (brk_l)
  );

  ramp_side #(.STEP(STEP), .BRAKE_TICKS(BRAKE_TICKS)) u_side_r (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .clear (estop),
    .tgt   (tgt_r),
    .cur   (rht),
    .state (st_r),
    .brake (brk_r)
  );

  assign at_tgt = (lft == tgt_l) && (st_l == RAMP) &&
                  (rht == tgt_r) && (st_r == RAMP);

endmodule

// File: tb/tb_motor_ramp_sched.sv
// tb/tb_motor_ramp_sched.sv - randomized self-checking bench for motor_ramp_sched
module tb_motor_ramp_sched;

  localparam int TICK_DIV    = 4;
  localparam int STEP        = 8;
  localparam int BRAKE_TICKS = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [10:0] cmd_lft = '0;
  logic signed [10:0] cmd_rht = '0;
  logic              cmd_vld = 1'b0;
  logic              cmd_rdy;
  logic              estop = 1'b0;
  logic signed [10:0] lft;
  logic signed [10:0] rht;
  logic              at_tgt;

  int n_cmp = 0;
  int n_err = 0;

  int m_cur[2];
  int m_tgt[2];
  int m_dwell[2];
  int m_cnt;
  bit last_tick;
  int lft_seq[$];

  motor_ramp_sched #(.TICK_DIV(TICK_DIV), .STEP(STEP), .BRAKE_TICKS(BRAKE_TICKS)) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd_lft (cmd_lft),
    .cmd_rht (cmd_rht),
    .cmd_vld (cmd_vld),
    .cmd_rdy (cmd_rdy),
    .estop   (estop),
    .lft     (lft),
    .rht     (rht),
    .at_tgt  (at_tgt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v < -1023) ? -1023 : v;
  endfunction

  function automatic int toward(input int c, input int a);
    if (a - c > STEP) return c + STEP;
    if (a - c < -STEP) return c - STEP;
    return a;
  endfunction

  task automatic side_tick(input int s);
    if (m_dwell[s] > 0) begin
      m_dwell[s]--;
    end else if (m_cur[s] != 0 && m_tgt[s] != 0 && ((m_cur[s] < 0) != (m_tgt[s] < 0))) begin
      m_cur[s] = toward(m_cur[s], 0);
      if (m_cur[s] == 0) m_dwell[s] = BRAKE_TICKS;
    end else begin
      m_cur[s] = toward(m_cur[s], m_tgt[s]);
    end
  endtask

  task automatic step(input bit r_rst, input bit r_estop, input bit vld, input int l, input int r);
    bit rdy_exp;
    bit tick;
    int exp_at;
    @(negedge clk);
    rst = r_rst; estop = r_estop; cmd_vld = vld;
    cmd_lft = 11'(l); cmd_rht = 11'(r);
    #1;
    rdy_exp = !r_estop && m_dwell[0] == 0 && m_dwell[1] == 0;
    check_val("cmd_rdy", int'(cmd_rdy), int'(rdy_exp));
    tick = 1'b0;
    if (r_rst || r_estop) begin
      m_cnt = 0;
      for (int s = 0; s < 2; s++) begin
        m_cur[s] = 0; m_tgt[s] = 0; m_dwell[s] = 0;
      end
    end else begin
      tick = (m_cnt == TICK_DIV - 1);
      if (tick) for (int s = 0; s < 2; s++) side_tick(s);
      if (vld && rdy_exp) begin
        m_tgt[0] = sat(l);
        m_tgt[1] = sat(r);
      end
      m_cnt = (m_cnt + 1) % TICK_DIV;
    end
    last_tick = tick;
    @(posedge clk);
    #1;
    exp_at = (m_cur[0] == m_tgt[0] && m_dwell[0] == 0 && m_cur[1] == m_tgt[1] && m_dwell[1] == 0) ? 1 : 0;
    check_val("lft", int'(lft), m_cur[0]);
    check_val("rht", int'(rht), m_cur[1]);
    check_val("at_tgt", int'(at_tgt), exp_at);
  endtask

  task automatic run_ticks(input int n, input bit vld, input int l, input int r);
    int seen = 0;
    lft_seq.delete();
    for (int c = 0; c < (n + 1) * TICK_DIV && seen < n; c++) begin
      step(1'b0, 1'b0, vld, l, r);
      if (last_tick) begin
        seen++;
        lft_seq.push_back(int'(lft));
      end
    end
    check_val("tick_count", seen, n);
  endtask

  task automatic check_seq(input string tag, input int e0, input int e1, input int e2);
    int exp[3];
    exp = '{e0, e1, e2};
    for (int i = 0; i < 3; i++)
      check_val($sformatf("%s[%0d]", tag, i), (i < lft_seq.size()) ? lft_seq[i] : 9999, exp[i]);
  endtask

  initial begin
    int l, r;
    repeat (2) @(posedge clk);

    // reset and idle
    repeat (3) step(1'b1, 1'b0, 1'b0, 0, 0);
    check_val("rst_lft", int'(lft), 0);
    check_val("rst_rht", int'(rht), 0);
    check_val("rst_rdy", int'(cmd_rdy), 1);
    check_val("rst_at_tgt", int'(at_tgt), 1);
    repeat (20) step(1'b0, 1'b0, 1'b0, 0, 0);

    // ramp up both sides
    step(1'b0, 1'b0, 1'b1, 20, -20);
    check_val("accept_at_tgt_drop", int'(at_tgt), 0);
    run_ticks(3, 1'b0, 0, 0);
    check_seq("ramp_up", 8, 16, 20);
    check_val("ramp_up_rht", int'(rht), -20);
    check_val("ramp_up_at_tgt", int'(at_tgt), 1);

    // reversal through zero with dwell; commands during the dwell are refused
    step(1'b0, 1'b0, 1'b1, -10, -20);
    run_ticks(3, 1'b0, 0, 0);
    check_seq("rev_down", 12, 4, 0);
    check_val("rev_brake_rdy", int'(cmd_rdy), 0);
    run_ticks(2, 1'b1, 50, 50);
    run_ticks(3, 1'b0, 0, 0);
    check_seq("rev_out", 0, -8, -10);
    check_val("rev_at_tgt", int'(at_tgt), 1);

    // -1024 saturates
    step(1'b0, 1'b0, 1'b1, -1024, 0);
    run_ticks(130, 1'b0, 0, 0);
    check_val("sat_lft", int'(lft), -1023);
    check_val("sat_at_tgt", int'(at_tgt), 1);

    // estop mid-ramp drops the concurrent command
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 40, 0);
    run_ticks(2, 1'b0, 0, 0);
    check_val("pre_estop_lft", int'(lft), 16);
    step(1'b0, 1'b1, 1'b1, 100, 100);
    check_val("estop_lft", int'(lft), 0);
    check_val("estop_rdy", int'(cmd_rdy), 0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 0, 0);
    run_ticks(5, 1'b0, 0, 0);
    check_val("post_estop_lft", int'(lft), 0);
    check_val("post_estop_rht", int'(rht), 0);

    // retarget mid-ramp, then reset during brake
    step(1'b0, 1'b0, 1'b1, 40, 0);
    run_ticks(1, 1'b0, 0, 0);
    check_val("retgt_first", int'(lft), 8);
    step(1'b0, 1'b0, 1'b1, 12, 0);
    run_ticks(2, 1'b0, 0, 0);
    check_val("retgt_lft", lft_seq[0], 12);
    check_val("retgt_hold", lft_seq[1], 12);
    step(1'b0, 1'b0, 1'b1, -30, 0);
    run_ticks(2, 1'b0, 0, 0);
    check_val("brake_lft", int'(lft), 0);
    check_val("brake_rdy", int'(cmd_rdy), 0);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    check_val("brake_rst_lft", int'(lft), 0);
    check_val("brake_rst_rdy", int'(cmd_rdy), 1);
    check_val("brake_rst_at_tgt", int'(at_tgt), 1);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) l = -1024;
      else if ($urandom_range(0, 1) == 0) l = int'($urandom_range(0, 80)) - 40;
      else l = int'($urandom_range(0, 2047)) - 1024;
      r = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 80)) - 40
                                      : int'($urandom_range(0, 2047)) - 1024;
      step($urandom_range(0, 999) < 2, $urandom_range(0, 99) < 2,
           $urandom_range(0, 9) < 2, l, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
